uart_rx_fifo: RTL and testbench

Receive-side byte buffer between the UART receiver's `rxnew`/`rxdata` strobe outputs and the memory mapper's CPU bus. It captures every received byte into a circular FIFO so that no byte is lost while the multi-cycle CPU is busy. It exposes data, status, control and flush registers on a 3-bit word-addressed slave port, and raises a level interrupt toward the interrupt unit when occupancy reaches a programmable threshold.

---
 rtl/uart_rx_fifo_if.sv | 24 ++
 rtl/uart_rx_fifo.sv | 161 ++++++++++++++++
 tb/tb_uart_rx_fifo.sv | 209 ++++++++++++++++++++
 3 files changed

// File: rtl/uart_rx_fifo_if.sv
`default_nettype none
// ============================================================================
// Module      : uart_rx_fifo_if
// Description : Word-addressed CPU register bus between the memory mapper
//               (master) and the receive FIFO (slave).
//               a     - register word index
//               d     - write data
//               we/rd - write/read request, held until ready
//               spo   - registered read data
//               ready - access acknowledge
// Revision    : 1.0 - initial release
// ============================================================================
interface uart_rx_fifo_if;
  logic [2:0]  a;
  logic [31:0] d;
  logic        we;
  logic        rd;
  logic [31:0] spo;
  logic        ready;

  modport master (output a, d, we, rd, input spo, ready);
  modport slave  (input a, d, we, rd, output spo, ready);
endinterface
`default_nettype wire

// File: rtl/uart_rx_fifo.sv
`default_nettype none
// ============================================================================
// Module      : uart_rx_fifo
// Description : Receive byte FIFO between the UART receiver strobe and the
//               CPU bus, with DATA/STATUS/CTRL/FLUSH registers and a level
//               interrupt on a programmable occupancy threshold.
//   clk    - system clock
//   rst_n  - asynchronous active-low reset
//   rxnew  - one-cycle strobe, rxdata holds a new byte
//   rxdata - received byte
//   bus    - register slave port (a, d, we, rd, spo, ready)
//   irq    - level interrupt request
// Revision    : 1.0 - initial release
// ============================================================================
module uart_rx_fifo #(
  parameter int DEPTH_LOG2 = 4
) (
  input  wire logic        clk,
  input  wire logic        rst_n,
  input  wire logic        rxnew,
  input  wire logic [7:0]  rxdata,
  uart_rx_fifo_if.slave    bus,
  output logic             irq
);

  localparam int CW = DEPTH_LOG2 + 1;
  localparam logic [CW-1:0] c_depth = {1'b1, {DEPTH_LOG2{1'b0}}};

  logic [7:0]            mem_q [0:(1<<DEPTH_LOG2)-1];
  logic [DEPTH_LOG2-1:0] rp_q, rp_d, wp_q, wp_d;
  logic [CW-1:0]         count_q, count_d;
  logic                  ovf_q, ovf_d;
  logic                  irq_en_q, irq_en_d;
  logic [CW-1:0]         thr_q, thr_d;
  logic                  rd_q, we_q;
  logic                  ready_q;
  logic [31:0]           spo_q;
  logic                  irq_q, irq_d;

  logic                  w_rd_e, w_we_e;
  logic                  w_empty, w_full;
  logic                  w_pop, w_push, w_flush, w_ovf_set, w_ovf_clr;
  logic [CW-1:0]         w_thr_eff;
  logic [31:0]           w_rdata;
  logic                  w_unused_d;

  // Side effects fire only on the rising edge of a request.
  assign w_rd_e  = bus.rd & ~rd_q;
  assign w_we_e  = bus.we & ~we_q;
  assign w_empty = (count_q == '0);
  assign w_full  = (count_q == c_depth);

  assign w_flush = w_we_e && (bus.a == 3'd3);
  assign w_pop   = w_rd_e && (bus.a == 3'd0) && !w_empty;
  // A pop in the same cycle frees a slot, so a full FIFO still accepts the
  // byte. Flush discards any concurrent byte without flagging overflow.
  assign w_push    = rxnew && (!w_full || w_pop) && !w_flush;
  assign w_ovf_set = rxnew && w_full && !w_pop && !w_flush;
  assign w_ovf_clr = w_flush || (w_we_e && (bus.a == 3'd1) && bus.d[2]);

  assign w_unused_d = ^{bus.d[31:8+CW], bus.d[7:3], bus.d[1]};

  always_comb begin
    rp_d  = rp_q;
    wp_d  = wp_q;
    count_d = count_q;
    if (w_flush) begin
      rp_d    = '0;
      wp_d    = '0;
      count_d = '0;
    end else begin
      if (w_push) wp_d = wp_q + 1'b1;
      if (w_pop)  rp_d = rp_q + 1'b1;
      if (w_push && !w_pop)      count_d = count_q + 1'b1;
      else if (w_pop && !w_push) count_d = count_q - 1'b1;
    end
  end

  // Overflow set takes priority over a same-cycle clear.
  always_comb begin
    ovf_d = ovf_q;
    if (w_ovf_set)      ovf_d = 1'b1;
    else if (w_ovf_clr) ovf_d = 1'b0;
  end

  always_comb begin
    irq_en_d = irq_en_q;
    thr_d    = thr_q;
    if (w_we_e && (bus.a == 3'd2)) begin
      irq_en_d = bus.d[0];
      thr_d    = bus.d[8 +: CW];
    end
  end

  // Interrupt uses post-update state so it tracks the new occupancy a
  // single cycle after the change.
  assign w_thr_eff = (thr_d == '0) ? {{(CW-1){1'b0}}, 1'b1} : thr_d;
  assign irq_d     = irq_en_d && (count_d >= w_thr_eff);

  // Read data reflects pre-update state. An empty DATA read returns zero
  // rather than stale storage contents.
  always_comb begin
    w_rdata = '0;
    case (bus.a)
      3'd0: begin
        w_rdata[8]   = !w_empty;
        w_rdata[7:0] = w_empty ? 8'h00 : mem_q[rp_q];
      end
      3'd1: begin
        w_rdata[0]      = !w_empty;
        w_rdata[1]      = w_full;
        w_rdata[2]      = ovf_q;
        w_rdata[8 +: CW] = count_q;
      end
      3'd2: begin
        w_rdata[0]      = irq_en_q;
        w_rdata[8 +: CW] = thr_q;
      end
      default: w_rdata = '0;
    endcase
  end

  // Storage is intentionally left out of reset.
  always_ff @(posedge clk) begin
    if (w_push) mem_q[wp_q] <= rxdata;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rp_q     <= '0;
      wp_q     <= '0;
      count_q  <= '0;
      ovf_q    <= 1'b0;
      irq_en_q <= 1'b0;
      thr_q    <= {{(CW-1){1'b0}}, 1'b1};
      rd_q     <= 1'b0;
      we_q     <= 1'b0;
      ready_q  <= 1'b0;
      spo_q    <= '0;
      irq_q    <= 1'b0;
    end else begin
      rp_q     <= rp_d;
      wp_q     <= wp_d;
      count_q  <= count_d;
      ovf_q    <= ovf_d;
      irq_en_q <= irq_en_d;
      thr_q    <= thr_d;
      rd_q     <= bus.rd;
      we_q     <= bus.we;
      ready_q  <= bus.rd | bus.we;
      irq_q    <= irq_d;
      if (w_rd_e) spo_q <= w_rdata;
    end
  end

  assign bus.spo   = spo_q;
  assign bus.ready = ready_q;
  assign irq       = irq_q;

endmodule
`default_nettype wire

// File: tb/tb_uart_rx_fifo.sv
`default_nettype none
// ============================================================================
// Module      : tb_uart_rx_fifo
// Description : Directed self-checking bench for uart_rx_fifo.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_uart_rx_fifo;

  logic       clk;
  logic       rst_n;
  logic       rxnew;
  logic [7:0] rxdata;
  logic       irq;
  int         checks;
  int         failures;
  logic [31:0] v;

  uart_rx_fifo_if bus();

  uart_rx_fifo #(.DEPTH_LOG2(4)) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .rxnew  (rxnew),
    .rxdata (rxdata),
    .bus    (bus),
    .irq    (irq)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  task automatic push(input logic [7:0] b);
    @(negedge clk);
    rxnew  = 1'b1;
    rxdata = b;
    @(negedge clk);
    rxnew  = 1'b0;
  endtask

  task automatic reg_read(input logic [2:0] addr, output logic [31:0] val);
    @(negedge clk);
    bus.a  = addr;
    bus.rd = 1'b1;
    @(negedge clk);
    val = bus.spo;
    chk("read_ready", {31'b0, bus.ready}, 32'h1);
    bus.rd = 1'b0;
    @(negedge clk);
  endtask

  task automatic reg_write(input logic [2:0] addr, input logic [31:0] data);
    @(negedge clk);
    bus.a  = addr;
    bus.d  = data;
    bus.we = 1'b1;
    @(negedge clk);
    chk("write_ready", {31'b0, bus.ready}, 32'h1);
    bus.we = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    rst_n  = 1'b0;
    rxnew  = 1'b0;
    rxdata = 8'h00;
    bus.a  = 3'd0;
    bus.d  = 32'h0;
    bus.we = 1'b0;
    bus.rd = 1'b0;

    // Reset state
    repeat (2) @(negedge clk);
    chk("rst_spo",   bus.spo, 32'h0);
    chk("rst_ready", {31'b0, bus.ready}, 32'h0);
    chk("rst_irq",   {31'b0, irq}, 32'h0);
    rst_n = 1'b1;

    // Two bytes in, two out
    push(8'h41);
    push(8'h42);
    reg_read(3'd1, v); chk("status_two", v, 32'h0000_0201);
    reg_read(3'd0, v); chk("data_41", v, 32'h0000_0141);
    reg_read(3'd0, v); chk("data_42", v, 32'h0000_0142);
    reg_read(3'd1, v); chk("status_empty", v, 32'h0);
    reg_read(3'd0, v); chk("data_empty", v, 32'h0);
    reg_read(3'd3, v); chk("flush_read", v, 32'h0);
    reg_read(3'd5, v); chk("unmapped_read", v, 32'h0);

    // Fill, overflow, clear overflow
    for (int i = 0; i < 16; i++) push(8'(i));
    reg_read(3'd1, v); chk("status_full", v, 32'h0000_1003);
    push(8'hAA);
    reg_read(3'd1, v); chk("status_ovf", v, 32'h0000_1007);
    reg_write(3'd1, 32'h4);
    reg_read(3'd1, v); chk("status_ovf_clr", v, 32'h0000_1003);

    // Push and pop together while full
    @(negedge clk);
    bus.a  = 3'd0;
    bus.rd = 1'b1;
    rxnew  = 1'b1;
    rxdata = 8'h55;
    @(negedge clk);
    rxnew = 1'b0;
    chk("full_pushpop_data", bus.spo, 32'h0000_0100);
    bus.rd = 1'b0;
    @(negedge clk);
    reg_read(3'd1, v); chk("full_pushpop_status", v, 32'h0000_1003);
    for (int i = 1; i < 16; i++) begin
      reg_read(3'd0, v);
      chk("drain_order", v, 32'h100 | 32'(i));
    end
    reg_read(3'd0, v); chk("drain_last_55", v, 32'h0000_0155);
    reg_read(3'd1, v); chk("drain_empty", v, 32'h0);

    // Threshold interrupt
    reg_write(3'd2, 32'h301);
    reg_read(3'd2, v); chk("ctrl_readback", v, 32'h0000_0301);
    push(8'h01);
    push(8'h02);
    chk("irq_below_thr", {31'b0, irq}, 32'h0);
    push(8'h03);
    chk("irq_at_thr", {31'b0, irq}, 32'h1);
    @(negedge clk);
    bus.a  = 3'd0;
    bus.rd = 1'b1;
    @(negedge clk);
    chk("irq_after_pop", {31'b0, irq}, 32'h0);
    chk("irq_pop_data", bus.spo, 32'h0000_0101);
    bus.rd = 1'b0;
    @(negedge clk);
    reg_write(3'd2, 32'h001);
    chk("irq_thr0_count2", {31'b0, irq}, 32'h1);
    reg_write(3'd3, 32'h0);
    chk("irq_after_flush", {31'b0, irq}, 32'h0);
    push(8'h77);
    chk("irq_thr0_first", {31'b0, irq}, 32'h1);
    reg_write(3'd2, 32'h0);
    chk("irq_disabled", {31'b0, irq}, 32'h0);

    // Held read pops once
    push(8'h88);
    @(negedge clk);
    bus.a  = 3'd0;
    bus.rd = 1'b1;
    chk("hold_ready_c1", {31'b0, bus.ready}, 32'h0);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("hold_ready_held", {31'b0, bus.ready}, 32'h1);
    end
    @(negedge clk);
    bus.rd = 1'b0;
    chk("hold_ready_release", {31'b0, bus.ready}, 32'h1);
    chk("hold_data", bus.spo, 32'h0000_0177);
    @(negedge clk);
    chk("hold_ready_drop", {31'b0, bus.ready}, 32'h0);
    reg_read(3'd1, v); chk("hold_single_pop", v, 32'h0000_0101);

    // Flush with concurrent push
    for (int i = 0; i < 4; i++) push(8'hB0 + 8'(i));
    reg_read(3'd1, v); chk("five_queued", v, 32'h0000_0501);
    @(negedge clk);
    bus.a  = 3'd3;
    bus.d  = 32'h0;
    bus.we = 1'b1;
    rxnew  = 1'b1;
    rxdata = 8'h99;
    @(negedge clk);
    rxnew  = 1'b0;
    bus.we = 1'b0;
    @(negedge clk);
    reg_read(3'd1, v); chk("flush_with_push", v, 32'h0);

    // Asynchronous reset during a held read
    reg_write(3'd2, 32'h101);
    push(8'hC0);
    @(negedge clk);
    bus.a  = 3'd1;
    bus.rd = 1'b1;
    @(negedge clk);
    chk("pre_rst_ready", {31'b0, bus.ready}, 32'h1);
    chk("pre_rst_spo", bus.spo, 32'h0000_0101);
    chk("pre_rst_irq", {31'b0, irq}, 32'h1);
    #1 rst_n = 1'b0;
    #1;
    chk("async_rst_ready", {31'b0, bus.ready}, 32'h0);
    chk("async_rst_spo", bus.spo, 32'h0);
    chk("async_rst_irq", {31'b0, irq}, 32'h0);
    bus.rd = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    reg_read(3'd2, v); chk("rst_ctrl", v, 32'h0000_0100);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
